// File: rtl/pc_pkg.sv
// Shared constants and types for the program-counter block.
package pc_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_IDX_W = 26;
  localparam int unsigned IMM_W       = 16;
  localparam int unsigned PC_STEP     = 4;

  typedef logic [XLEN-1:0]        addr_t;
  typedef logic [INSTR_IDX_W-1:0] instr_idx_t;
  typedef logic [IMM_W-1:0]       imm_t;

  // Branch immediates count words; convert to a byte offset.
  function automatic addr_t word_to_byte(input addr_t words);
    return words << 2;
  endfunction

endpackage

// File: rtl/pc_if.sv
// Control-to-PC bundle: jump/branch selects and instruction field in, fetch address out.
interface pc_if;
  import pc_pkg::*;

  logic       jump;
  logic       pcsrc;
  instr_idx_t instr;
  addr_t      pc;

  modport master (output jump, output pcsrc, output instr, input  pc);
  modport slave  (input  jump, input  pcsrc, input  instr, output pc);
endinterface

// File: rtl/pc_adder.sv
// Modulo-2^32 address adder.
module pc_adder
  import pc_pkg::*;
(
  input  addr_t i_a,
  input  addr_t i_b,
  output addr_t o_y
);

  assign o_y = i_a + i_b;

endmodule

// File: rtl/pc_mux2.sv
// Two-way address select; i_sel=1 picks i_b.
module pc_mux2
  import pc_pkg::*;
(
  input  logic  i_sel,
  input  addr_t i_a,
  input  addr_t i_b,
  output addr_t o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/pc_reg.sv
// Fetch-address register with asynchronous active-low reset.
module pc_reg
  import pc_pkg::*;
#(
  parameter addr_t RESET_ADDR = '0
) (
  input  logic  clk,
  input  logic  reset,
  input  addr_t i_d,
  output addr_t o_q
);

  addr_t r_q;

  // Load next address each edge; reset forces the start address immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_q <= RESET_ADDR;
    else        r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/pc_sign_ext.sv
// Sign-extends the 16-bit branch immediate to address width.
module pc_sign_ext
  import pc_pkg::*;
(
  input  imm_t  i_imm,
  output addr_t o_y
);

  assign o_y = {{(XLEN-IMM_W){i_imm[IMM_W-1]}}, i_imm};

endmodule

// File: rtl/pc.sv
// Program counter and next-PC selection: sequential, PC-relative branch, or pseudo-direct jump.
module pc
  import pc_pkg::*;
#(
  parameter addr_t RESET_ADDR = 32'h0000_0000
) (
  input  logic clk,
  input  logic reset,
  pc_if.slave  bus
);

  addr_t w_pc;
  addr_t w_plus4;
  addr_t w_imm_ext;
  addr_t w_branch;
  addr_t w_jump;
  addr_t w_br_sel;
  addr_t w_next;

  pc_adder u_plus4 (
    .i_a (w_pc),
    .i_b (XLEN'(PC_STEP)),
    .o_y (w_plus4)
  );

  pc_sign_ext u_sext (
    .i_imm (bus.instr[IMM_W-1:0]),
    .o_y   (w_imm_ext)
  );

  pc_adder u_branch (
    .i_a (w_plus4),
    .i_b (word_to_byte(w_imm_ext)),
    .o_y (w_branch)
  );

  // Jump keeps the region bits of the sequential address.
  assign w_jump = {w_plus4[XLEN-1:XLEN-4], bus.instr, 2'b00};

  pc_mux2 u_br_mux (
    .i_sel (bus.pcsrc),
    .i_a   (w_plus4),
    .i_b   (w_branch),
    .o_y   (w_br_sel)
  );

  // Jump select sits after branch select, so jump wins when both are set.
  pc_mux2 u_jmp_mux (
    .i_sel (bus.jump),
    .i_a   (w_br_sel),
    .i_b   (w_jump),
    .o_y   (w_next)
  );

  pc_reg #(
    .RESET_ADDR (RESET_ADDR)
  ) u_reg (
    .clk   (clk),
    .reset (reset),
    .i_d   (w_next),
    .o_q   (w_pc)
  );

  assign bus.pc = w_pc;

endmodule

// File: tb/tb_pc.sv
// Self-checking bench for pc: directed sequence plus randomized traffic against a reference model.
module tb_pc;

  localparam logic [31:0] RST_A = 32'h0000_0000;
  localparam logic [31:0] RST_W = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pc_if bus();
  pc_if bus_w();

  pc #(.RESET_ADDR(RST_A)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Second instance parked near the top of the address space to exercise wrap-around.
  pc #(.RESET_ADDR(RST_W)) u_dut_w (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_w.slave)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  logic [31:0] m_pc;
  logic [31:0] m_pc_w;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference next-address rule written with plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input bit j, input bit s,
                                           input logic [25:0] ins);
    logic [31:0] seq;
    logic [15:0] imm;
    int          off;
    seq = cur + 32'd4;
    imm = ins[15:0];
    off = (imm >= 16'h8000) ? int'(imm) - 65536 : int'(imm);
    if (j) return (seq & 32'hF000_0000) | (32'(ins) * 32'd4);
    if (s) return seq + 32'(off * 4);
    return seq;
  endfunction

  // Called at a negedge: drive inputs, let one posedge happen, compare, return at negedge.
  task automatic step(input bit j, input bit s, input logic [25:0] ins);
    bus.jump  = j;
    bus.pcsrc = s;
    bus.instr = ins;
    m_pc   = ref_next(m_pc, j, s, ins);
    m_pc_w = ref_next(m_pc_w, 1'b0, 1'b0, 26'h0);
    @(posedge clk);
    #1;
    check("pc_step", bus.pc, m_pc);
    check("pc_wrap_step", bus_w.pc, m_pc_w);
    @(negedge clk);
  endtask

  // Called at a negedge: assert reset between edges, confirm async effect and hold, release.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    m_pc   = RST_A;
    m_pc_w = RST_W;
    check("rst_async", bus.pc, m_pc);
    check("rst_async_w", bus_w.pc, m_pc_w);
    bus.jump  = 1'b1;
    bus.pcsrc = 1'b1;
    bus.instr = 26'h3FF_FFFF;
    @(posedge clk);
    #1;
    check("rst_hold", bus.pc, m_pc);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bus.jump    = 1'b0;
    bus.pcsrc   = 1'b0;
    bus.instr   = '0;
    bus_w.jump  = 1'b0;
    bus_w.pcsrc = 1'b0;
    bus_w.instr = '0;
    m_pc   = RST_A;
    m_pc_w = RST_W;

    do_reset();
    step(0, 0, 26'h0);        check("seq_4",   bus.pc, 32'h4);
                              check("wrap_fc", bus_w.pc, 32'hFFFF_FFFC);
    step(0, 0, 26'h0);        check("seq_8",   bus.pc, 32'h8);
                              check("wrap_0",  bus_w.pc, 32'h0);
    step(0, 1, 26'h10);       check("br_4c",   bus.pc, 32'h4C);
    step(1, 0, 26'h20);       check("jmp_80",  bus.pc, 32'h80);

    do_reset();
    step(0, 0, 26'h0);        check("rel_4",   bus.pc, 32'h4);
    step(0, 0, 26'h0);        check("rel_8",   bus.pc, 32'h8);
    step(0, 0, 26'h0);        check("rel_c",   bus.pc, 32'hC);
    step(0, 1, 26'h100);      check("br_410",  bus.pc, 32'h410);
    step(1, 0, 26'h200);      check("jmp_800", bus.pc, 32'h800);
    step(1, 1, 26'h30);       check("jmp_pri", bus.pc, 32'hC0);
    step(1, 0, 26'h4);        check("jmp_10",  bus.pc, 32'h10);
    step(0, 1, 26'h000FFFF);  check("br_loop", bus.pc, 32'h10);
    step(0, 1, 26'h3FF8000);  check("br_min",  bus.pc, 32'hFFFE_0014);
    step(1, 0, 26'h3FF_FFFF); check("jmp_top", bus.pc, 32'hFFFF_FFFC);
    step(1, 0, 26'h3FF_FFFF); check("jmp_reg0", bus.pc, 32'h0FFF_FFFC);
    step(1, 0, 26'h0);        check("jmp_reg1", bus.pc, 32'h1000_0000);
    step(1, 0, 26'h1);        check("jmp_keep", bus.pc, 32'h1000_0004);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), 26'($urandom));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
